// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic DEPTH-stage pipeline register with valid tracking, stall, flush
// and bubble collapse. Define PIPE_STAGE_PERF_EN to build the stall/flush performance counters.

module pipe_stage_slot #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              move,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  input  logic [CTRL_W-1:0] src_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);
  always_ff @(posedge Clk) begin
    if (Reset || flush) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (move) begin
      valid <= src_valid;
      data  <= src_data;
      // a bubble must never carry live control (RegWrite, MemWrite...)
      ctrl  <= src_ctrl & {CTRL_W{src_valid}};
    end
  end
endmodule

module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_Valid,
  input  logic [DATA_W-1:0] in_Data,
  input  logic [CTRL_W-1:0] in_Ctrl,
  input  logic              in_Stall,
  input  logic              in_Flush,
  output logic              out_Valid,
  output logic [DATA_W-1:0] out_Data,
  output logic [CTRL_W-1:0] out_Ctrl,
  output logic              out_Full,
  output logic [31:0]       out_StallCycles,
  output logic [31:0]       out_FlushCount
);
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH must be in 1..4");
  end

  // index 0 is the input port, index k+1 is stage k
  logic [DEPTH:0]             vld_pipe;
  logic [DEPTH:0][DATA_W-1:0] data_pipe;
  logic [DEPTH:0][CTRL_W-1:0] ctrl_pipe;
  logic [DEPTH-1:0]           move;

  assign vld_pipe[0]  = in_Valid;
  assign data_pipe[0] = in_Data;
  assign ctrl_pipe[0] = in_Ctrl;

  // a stage may advance if the one after it advances or it is holding a bubble
  always_comb begin
    move = '0;
    move[DEPTH-1] = !in_Stall;
    for (int k = DEPTH - 2; k >= 0; k--)
      move[k] = move[k+1] | !vld_pipe[k+1];
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot (
      .Clk      (Clk),
      .Reset    (Reset),
      .flush    (in_Flush),
      .move     (move[k]),
      .src_valid(vld_pipe[k]),
      .src_data (data_pipe[k]),
      .src_ctrl (ctrl_pipe[k]),
      .valid    (vld_pipe[k+1]),
      .data     (data_pipe[k+1]),
      .ctrl     (ctrl_pipe[k+1])
    );
  end

  assign out_Valid = vld_pipe[DEPTH];
  assign out_Data  = data_pipe[DEPTH];
  assign out_Ctrl  = ctrl_pipe[DEPTH];
  assign out_Full  = !move[0];

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (in_Stall && out_Valid && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (in_Flush && flush_cnt != 32'hFFFF_FFFF)             flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign out_StallCycles = stall_cnt;
  assign out_FlushCount  = flush_cnt;
`else
  assign out_StallCycles = '0;
  assign out_FlushCount  = '0;
`endif
endmodule
